// File: rtl/pico_seq_pkg.sv
// Shared types and constants for the pico program sequencer.
// The sequencer loads a byte-serial program and issues it to the pico core.
package pico_seq_pkg;

  localparam int INSTR_W  = 16;
  localparam int OFFSET_W = 5;

  localparam logic [1:0] OPC_BRANCH = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_WAIT_BR = 2'd2,
    S_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/pico_prog_mem.sv
// Instruction buffer: DEPTH x INSTR_W registers.
// One synchronous write port and one combinational read port.
module pico_prog_mem
  import pico_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; contents are only meaningful below prog_len,
  // so the array maps to plain flops/RAM without a reset network.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pico_prog_sequencer.sv
// Program sequencer for the 8-bit pico core: byte-serial program load, then
// in-order instruction issue with branch redirect, halt and an issue limit.
module pico_prog_sequencer
  import pico_seq_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int MAX_ISSUE = 255,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_valid,
  input  logic [7:0]          ld_byte,
  output logic                ld_ready,
  input  logic                clr,
  input  logic                start,
  input  logic                halt_req,
  output logic                issue_valid,
  output logic [INSTR_W-1:0]  issue_instr,
  input  logic                issue_ready,
  input  logic                br_valid,
  input  logic                br_taken,
  input  logic [OFFSET_W-1:0] br_offset,
  output logic                busy,
  output logic                done,
  output logic                limit_err,
  output logic [AW-1:0]       pc,
  output logic [AW:0]         prog_len
);

  // Branch targets are formed wide enough that pc+offset never wraps.
  localparam int TW = ((AW > OFFSET_W) ? AW : OFFSET_W) + 1;

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);
  localparam logic [7:0]  CNT_MAX = 8'(MAX_ISSUE);

  state_e             state_q;
  logic [AW-1:0]      pc_q;
  logic [AW:0]        len_q;
  logic               ld_tog_q;
  logic [7:0]         ld_lo_q;
  logic [7:0]         cnt_q;
  logic               lim_q;
  logic               halt_q;

  logic               ld_fire;
  logic               mem_we;
  logic [INSTR_W-1:0] rd_data;
  logic               fire;
  logic               is_branch;
  logic [AW:0]        pc_inc;
  logic [7:0]         cnt_inc;
  logic               lim_hit;
  logic [TW-1:0]      pc_ext;
  logic [TW-1:0]      len_ext;
  logic [TW-1:0]      br_target;

  assign ld_ready = (state_q == S_IDLE) && (len_q < LEN_MAX);
  assign ld_fire  = ld_valid && ld_ready;
  // clr and start take priority over a byte arriving in the same cycle.
  assign mem_we   = ld_fire && ld_tog_q && !clr && !start;

  pico_prog_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (mem_we),
    .waddr_i(len_q[AW-1:0]),
    .wdata_i({ld_byte, ld_lo_q}),
    .raddr_i(pc_q),
    .rdata_o(rd_data)
  );

  assign issue_valid = (state_q == S_RUN);
  assign issue_instr = issue_valid ? rd_data : '0;
  assign fire        = issue_valid && issue_ready;
  assign is_branch   = (rd_data[1:0] == OPC_BRANCH);

  assign pc_inc  = {1'b0, pc_q} + LEN_ONE;
  assign cnt_inc = cnt_q + 8'd1;
  assign lim_hit = (cnt_inc == CNT_MAX);

  assign pc_ext    = TW'(pc_q);
  assign len_ext   = TW'(len_q);
  assign br_target = br_taken ? (pc_ext + TW'(br_offset)) : (pc_ext + TW'(1));

  assign busy      = (state_q == S_RUN) || (state_q == S_WAIT_BR);
  assign done      = (state_q == S_DONE);
  assign limit_err = lim_q;
  assign pc        = pc_q;
  assign prog_len  = len_q;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      ld_tog_q <= 1'b0;
      ld_lo_q  <= '0;
      cnt_q    <= '0;
      lim_q    <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (clr) begin
            len_q    <= '0;
            ld_tog_q <= 1'b0;
            lim_q    <= 1'b0;
            state_q  <= S_IDLE;
          end else if (start) begin
            ld_tog_q <= 1'b0;
            if (len_q == '0) begin
              state_q <= S_DONE;
            end else begin
              pc_q    <= '0;
              cnt_q   <= '0;
              lim_q   <= 1'b0;
              halt_q  <= 1'b0;
              state_q <= S_RUN;
            end
          end else if (ld_fire) begin
            if (!ld_tog_q) begin
              ld_lo_q  <= ld_byte;
              ld_tog_q <= 1'b1;
            end else begin
              len_q    <= len_q + LEN_ONE;
              ld_tog_q <= 1'b0;
            end
          end
        end

        S_RUN: begin
          if (fire) begin
            cnt_q <= cnt_inc;
            // Limit first, then halt, then the instruction's own successor.
            if (lim_hit) begin
              lim_q   <= 1'b1;
              state_q <= S_DONE;
            end else if (halt_req) begin
              state_q <= S_DONE;
            end else if (is_branch) begin
              state_q <= S_WAIT_BR;
            end else if (pc_inc == len_q) begin
              state_q <= S_DONE;
            end else begin
              pc_q <= pc_inc[AW-1:0];
            end
          end else if (halt_req) begin
            state_q <= S_DONE;
          end
        end

        S_WAIT_BR: begin
          if (br_valid) begin
            halt_q <= 1'b0;
            if (halt_q || halt_req) begin
              state_q <= S_DONE;
            end else if (br_target >= len_ext) begin
              state_q <= S_DONE;
            end else begin
              pc_q    <= br_target[AW-1:0];
              state_q <= S_RUN;
            end
          end else if (halt_req) begin
            halt_q <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pico_prog_sequencer.sv
// Directed bench for pico_prog_sequencer: a table of load/run vectors plus
// hand-written sequences for stall, halt, issue limit and load corner cases.
module tb_pico_prog_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid, clr, start, halt_req, issue_ready, br_valid, br_taken;
  logic [7:0]  ld_byte;
  logic [4:0]  br_offset;

  logic        ld_ready, issue_valid, busy, done, limit_err;
  logic [15:0] issue_instr;
  logic [2:0]  pc;
  logic [3:0]  prog_len;

  logic        l_ld_ready, l_issue_valid, l_busy, l_done, l_limit_err;
  logic [15:0] l_issue_instr;
  logic [2:0]  l_pc;
  logic [3:0]  l_prog_len;

  always #5 clk = ~clk;

  pico_prog_sequencer #(.DEPTH(8), .MAX_ISSUE(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(ld_ready),
    .clr(clr), .start(start), .halt_req(halt_req),
    .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_ready(issue_ready),
    .br_valid(br_valid), .br_taken(br_taken), .br_offset(br_offset),
    .busy(busy), .done(done), .limit_err(limit_err), .pc(pc), .prog_len(prog_len)
  );

  // Second instance with a small issue limit, sharing all stimulus.
  pico_prog_sequencer #(.DEPTH(8), .MAX_ISSUE(4)) dut_lim (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(l_ld_ready),
    .clr(clr), .start(start), .halt_req(halt_req),
    .issue_valid(l_issue_valid), .issue_instr(l_issue_instr), .issue_ready(issue_ready),
    .br_valid(br_valid), .br_taken(br_taken), .br_offset(br_offset),
    .busy(l_busy), .done(l_done), .limit_err(l_limit_err), .pc(l_pc), .prog_len(l_prog_len)
  );

  typedef struct packed {
    logic [3:0][15:0] prog;
    logic [3:0]       len;
    logic             reload;
    logic             taken;
    logic [4:0]       off;
    logic [3:0]       exp_n;
    logic [3:0][15:0] exp_instr;
    logic [3:0][2:0]  exp_pc;
    logic [3:0]       exp_cycles;
  } vec_t;

  vec_t        vecs [4];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] cap_instr [16];
  logic [2:0]  cap_pc [16];
  int          cap_n;
  int          cap_cycles;
  logic        done_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic load_byte(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_byte  = b;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic load_word(input logic [15:0] w);
    load_byte(w[7:0]);
    load_byte(w[15:8]);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Start a run with issue_ready held high and answer every branch with the
  // given outcome; record each issued instruction and the cycles to DONE.
  task automatic run_prog(input logic taken, input logic [4:0] off, input int budget);
    cap_n       = 0;
    cap_cycles  = -1;
    done_seen   = 1'b0;
    br_taken    = taken;
    br_offset   = off;
    issue_ready = 1'b1;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done) begin
        done_seen  = 1'b1;
        cap_cycles = c;
        break;
      end
      if (issue_valid) begin
        if (cap_n < 16) begin
          cap_instr[cap_n] = issue_instr;
          cap_pc[cap_n]    = pc;
        end
        cap_n++;
      end
      br_valid = busy && !issue_valid;
      @(negedge clk);
    end
    br_valid = 1'b0;
    check("run_reaches_done", 32'(done_seen), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic stable;
    logic rdy_ok;
    logic rdy_last;
    int   lim_n;
    logic lim_seen;
    logic lim_instr_ok;

    vecs[0] = '0;
    vecs[0].prog       = {16'h0000, 16'h2021, 16'h0109, 16'h0004};
    vecs[0].len        = 4'd3;
    vecs[0].reload     = 1'b1;
    vecs[0].exp_n      = 4'd3;
    vecs[0].exp_instr  = {16'h0000, 16'h2021, 16'h0109, 16'h0004};
    vecs[0].exp_pc     = {3'd0, 3'd2, 3'd1, 3'd0};
    vecs[0].exp_cycles = 4'd3;

    vecs[1] = '0;
    vecs[1].prog       = {16'h0006, 16'h0005, 16'h0203, 16'h0001};
    vecs[1].len        = 4'd4;
    vecs[1].reload     = 1'b1;
    vecs[1].taken      = 1'b1;
    vecs[1].off        = 5'd2;
    vecs[1].exp_n      = 4'd3;
    vecs[1].exp_instr  = {16'h0000, 16'h0006, 16'h0203, 16'h0001};
    vecs[1].exp_pc     = {3'd0, 3'd3, 3'd1, 3'd0};
    vecs[1].exp_cycles = 4'd4;

    vecs[2] = vecs[1];
    vecs[2].taken      = 1'b0;
    vecs[2].exp_n      = 4'd4;
    vecs[2].exp_instr  = {16'h0006, 16'h0005, 16'h0203, 16'h0001};
    vecs[2].exp_pc     = {3'd3, 3'd2, 3'd1, 3'd0};
    vecs[2].exp_cycles = 4'd5;

    vecs[3] = vecs[1];
    vecs[3].reload     = 1'b0;
    vecs[3].off        = 5'd5;
    vecs[3].exp_n      = 4'd2;
    vecs[3].exp_instr  = {16'h0000, 16'h0000, 16'h0203, 16'h0001};
    vecs[3].exp_pc     = {3'd0, 3'd0, 3'd1, 3'd0};
    vecs[3].exp_cycles = 4'd3;

    rst_n = 1'b0; ld_valid = 1'b0; ld_byte = '0; clr = 1'b0; start = 1'b0;
    halt_req = 1'b0; issue_ready = 1'b0; br_valid = 1'b0; br_taken = 1'b0; br_offset = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_ld_ready",    32'(ld_ready),    32'(1));
    check("rst_issue_valid", 32'(issue_valid), 32'(0));
    check("rst_issue_instr", 32'(issue_instr), 32'(0));
    check("rst_busy",        32'(busy),        32'(0));
    check("rst_done",        32'(done),        32'(0));
    check("rst_limit_err",   32'(limit_err),   32'(0));
    check("rst_pc",          32'(pc),          32'(0));
    check("rst_prog_len",    32'(prog_len),    32'(0));

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].reload) begin
        pulse_clr();
        for (int i = 0; i < int'(vecs[v].len); i++) load_word(vecs[v].prog[i]);
      end
      run_prog(vecs[v].taken, vecs[v].off, 40);
      check($sformatf("v%0d_issue_count", v), 32'(cap_n), 32'(vecs[v].exp_n));
      check($sformatf("v%0d_cycles", v), 32'(cap_cycles), 32'(vecs[v].exp_cycles));
      for (int i = 0; i < int'(vecs[v].exp_n); i++) begin
        check($sformatf("v%0d_instr%0d", v, i), 32'(cap_instr[i]), 32'(vecs[v].exp_instr[i]));
        check($sformatf("v%0d_pc%0d", v, i), 32'(cap_pc[i]), 32'(vecs[v].exp_pc[i]));
      end
      check($sformatf("v%0d_prog_len", v), 32'(prog_len), 32'(vecs[v].len));
      check($sformatf("v%0d_busy", v), 32'(busy), 32'(0));
      check($sformatf("v%0d_limit_err", v), 32'(limit_err), 32'(0));
    end

    // Branch to itself forever; the MAX_ISSUE=4 instance must stop on the limit.
    pulse_clr();
    load_word(16'h0003);
    issue_ready = 1'b1; br_taken = 1'b1; br_offset = 5'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lim_n = 0; lim_seen = 1'b0; lim_instr_ok = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (l_done) begin
        lim_seen = 1'b1;
        break;
      end
      if (l_issue_valid) begin
        lim_n++;
        if (l_issue_instr !== 16'h0003) lim_instr_ok = 1'b0;
      end
      br_valid = busy && !issue_valid;
      @(negedge clk);
    end
    br_valid = 1'b0;
    check("lim_reaches_done", 32'(lim_seen), 32'(1));
    check("lim_issue_count", 32'(lim_n), 32'(4));
    check("lim_instr", 32'(lim_instr_ok), 32'(1));
    check("lim_limit_err", 32'(l_limit_err), 32'(1));
    check("main_still_busy", 32'(busy), 32'(1));
    check("main_no_limit_err", 32'(limit_err), 32'(0));

    // halt_req while waiting for a branch is held until br_valid.
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    check("halt_wait_pending", 32'(busy), 32'(1));
    check("halt_wait_no_issue", 32'(issue_valid), 32'(0));
    br_valid = 1'b1;
    @(negedge clk);
    br_valid = 1'b0;
    check("halt_wait_done", 32'(done), 32'(1));

    // Back-pressure, then halt together with a fire.
    pulse_clr();
    load_word(16'h0004); load_word(16'h0109); load_word(16'h2021);
    issue_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!issue_valid || issue_instr !== 16'h0004 || pc !== 3'd0) stable = 1'b0;
      @(negedge clk);
    end
    check("stall_stable", 32'(stable), 32'(1));
    check("stall_pc", 32'(pc), 32'(0));
    issue_ready = 1'b1;
    @(negedge clk);
    check("after_stall_instr", 32'(issue_instr), 32'h0109);
    check("after_stall_pc", 32'(pc), 32'(1));
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    issue_ready = 1'b0;
    check("halt_fire_done", 32'(done), 32'(1));
    check("halt_fire_no_valid", 32'(issue_valid), 32'(0));
    @(negedge clk);
    check("halt_fire_stays_idle", 32'(issue_valid), 32'(0));

    // halt_req with no fire stops at once; program is retained for rerun.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rerun_valid", 32'(issue_valid), 32'(1));
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    check("halt_nofire_done", 32'(done), 32'(1));
    check("halt_nofire_valid", 32'(issue_valid), 32'(0));

    // Overfill: 17 bytes into 8 entries.
    pulse_clr();
    rdy_ok = 1'b1; rdy_last = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) begin
        if (!ld_ready) rdy_ok = 1'b0;
      end else begin
        rdy_last = ld_ready;
      end
      ld_valid = 1'b1;
      ld_byte  = 8'(8'h10 + i);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    check("fill_ready_high", 32'(rdy_ok), 32'(1));
    check("fill_ready_low", 32'(rdy_last), 32'(0));
    check("fill_prog_len", 32'(prog_len), 32'(8));
    run_prog(1'b0, 5'd0, 40);
    check("fill_issue_count", 32'(cap_n), 32'(8));
    check("fill_first", 32'(cap_instr[0]), 32'h1110);
    check("fill_last", 32'(cap_instr[7]), 32'h1F1E);

    // Dangling low byte is discarded by start.
    pulse_clr();
    load_byte(8'h04); load_byte(8'h00); load_byte(8'h55);
    run_prog(1'b0, 5'd0, 20);
    check("odd_prog_len", 32'(prog_len), 32'(1));
    check("odd_issue_count", 32'(cap_n), 32'(1));
    check("odd_instr", 32'(cap_instr[0]), 32'h0004);
    check("odd_cycles", 32'(cap_cycles), 32'(1));

    // Empty program goes straight to DONE.
    pulse_clr();
    run_prog(1'b0, 5'd0, 10);
    check("empty_issue_count", 32'(cap_n), 32'(0));
    check("empty_cycles", 32'(cap_cycles), 32'(0));

    // Asynchronous reset in the middle of a stalled run.
    pulse_clr();
    load_word(16'h0004);
    issue_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("pre_reset_valid", 32'(issue_valid), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(issue_valid), 32'(0));
    check("async_reset_len", 32'(prog_len), 32'(0));
    check("async_reset_ready", 32'(ld_ready), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
